// File: rtl/miner_job_driver_pkg.sv
// Shared widths, default geometry and FSM encoding for the miner job driver.
package miner_job_driver_pkg;

  localparam int unsigned WORD_S         = 32;
  localparam int unsigned JOB_WORDS_D    = 20;
  localparam int unsigned RESULT_WORDS_D = 8;
  localparam int unsigned NONCE_INDEX_D  = 19;
  localparam int unsigned CNT_W_D        = 16;
  localparam int unsigned ADDR_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RECV,
    ST_UPDATE
  } state_e;

endpackage

// File: rtl/miner_job_driver_if.sv
// AXI-Stream link between the job driver and the miner core.
interface miner_job_driver_if #(
  parameter int unsigned W = 32
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic [W/8-1:0] tstrb;
  logic         tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/miner_result_capture.sv
// Assembles the returned hash packet word by word and flags tlast misplacement.
module miner_result_capture #(
  parameter int unsigned W     = 32,
  parameter int unsigned WORDS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               tvalid_i,
  input  logic [W-1:0]       tdata_i,
  input  logic               tlast_i,
  output logic [WORDS*W-1:0] result_data_o,
  output logic               pkt_done_c,
  output logic               pkt_err_c
);

  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  logic [IW-1:0] widx_q;
  logic [W-1:0]  word_q [WORDS];
  logic          hs;
  logic          last_word;

  assign hs         = en_i & tvalid_i;
  assign last_word  = (widx_q == LAST);
  assign pkt_done_c = hs & (last_word | tlast_i);
  // Early tlast and missing tlast are both the same mismatch.
  assign pkt_err_c  = hs & (last_word ^ tlast_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx_q <= '0;
      for (int i = 0; i < int'(WORDS); i++) word_q[i] <= '0;
    end else if (hs) begin
      word_q[widx_q] <= tdata_i;
      widx_q         <= pkt_done_c ? '0 : widx_q + IW'(1);
    end
  end

  // Word 0 lands in the most significant slot.
  for (genvar g = 0; g < int'(WORDS); g++) begin : g_pack
    assign result_data_o[(int'(WORDS) - 1 - g)*int'(W) +: int'(W)] = word_q[g];
  end

endmodule

// File: rtl/miner_job_driver.sv
// Streams a stored block-header job to the miner, collects the hash, and sweeps the nonce.
module miner_job_driver
  import miner_job_driver_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = WORD_S,
  parameter int unsigned JOB_WORDS          = JOB_WORDS_D,
  parameter int unsigned RESULT_WORDS       = RESULT_WORDS_D,
  parameter int unsigned NONCE_INDEX        = NONCE_INDEX_D,
  parameter int unsigned CNT_W              = CNT_W_D
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_aresetn,
  input  logic                                 cfg_we,
  input  logic [ADDR_W-1:0]                    cfg_addr,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]        cfg_wdata,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     run_count,
  input  logic                                 stop,
  output logic                                 busy,
  output logic                                 done,
  output logic [CNT_W-1:0]                     jobs_done,
  output logic [C_AXIS_TDATA_WIDTH-1:0]        cur_nonce,
  output logic [RESULT_WORDS*C_AXIS_TDATA_WIDTH-1:0] result_data,
  output logic                                 result_valid,
  output logic                                 proto_err,
  miner_job_driver_if.master                   m00_axis,
  miner_job_driver_if.slave                    s00_axis
);

  localparam int unsigned W  = C_AXIS_TDATA_WIDTH;
  localparam int unsigned IW = $clog2(JOB_WORDS);
  localparam logic [IW-1:0]     JOB_LAST   = IW'(JOB_WORDS - 1);
  localparam logic [ADDR_W-1:0] JOB_LAST_A = ADDR_W'(JOB_WORDS - 1);

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_nx;
  logic [CNT_W-1:0] jobs_left_q;
  logic [CNT_W-1:0] jobs_done_q;
  logic             stop_q;
  logic             busy_q;
  logic             done_q;
  logic             rv_q;
  logic             perr_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic [W-1:0]     tdata_q;
  logic             s_tready_q;
  logic [W-1:0]     job_q [JOB_WORDS];
  logic             pkt_done_c;
  logic             pkt_err_c;

  assign idx_nx = idx_q + IW'(1);

  miner_result_capture #(
    .W     (W),
    .WORDS (RESULT_WORDS)
  ) u_capture (
    .clk           (axis_aclk),
    .rst_n         (axis_aresetn),
    .en_i          (s_tready_q),
    .tvalid_i      (s00_axis.tvalid),
    .tdata_i       (s00_axis.tdata),
    .tlast_i       (s00_axis.tlast),
    .result_data_o (result_data),
    .pkt_done_c    (pkt_done_c),
    .pkt_err_c     (pkt_err_c)
  );

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      jobs_left_q <= '0;
      jobs_done_q <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rv_q        <= 1'b0;
      perr_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      s_tready_q  <= 1'b0;
      for (int i = 0; i < int'(JOB_WORDS); i++) job_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      rv_q   <= 1'b0;
      // Stop is remembered for the rest of the run; a start below clears it.
      if (state_q != ST_IDLE && stop) stop_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SEND;
            busy_q      <= 1'b1;
            jobs_left_q <= (run_count == '0) ? CNT_W'(1) : run_count;
            jobs_done_q <= '0;
            perr_q      <= 1'b0;
            stop_q      <= 1'b0;
            idx_q       <= '0;
            tvalid_q    <= 1'b1;
            tdata_q     <= job_q[0];
            tlast_q     <= (JOB_LAST == '0);
          end else if (cfg_we && cfg_addr <= JOB_LAST_A) begin
            job_q[cfg_addr] <= cfg_wdata;
          end
        end

        ST_SEND: begin
          if (m00_axis.tready) begin
            if (idx_q == JOB_LAST) begin
              state_q    <= ST_RECV;
              tvalid_q   <= 1'b0;
              tlast_q    <= 1'b0;
              s_tready_q <= 1'b1;
              idx_q      <= '0;
            end else begin
              idx_q   <= idx_nx;
              tdata_q <= job_q[idx_nx];
              tlast_q <= (idx_nx == JOB_LAST);
            end
          end
        end

        ST_RECV: begin
          if (pkt_done_c) begin
            state_q             <= ST_UPDATE;
            s_tready_q          <= 1'b0;
            rv_q                <= 1'b1;
            jobs_done_q         <= jobs_done_q + CNT_W'(1);
            job_q[NONCE_INDEX]  <= job_q[NONCE_INDEX] + W'(1);
            if (pkt_err_c) perr_q <= 1'b1;
            done_q <= (jobs_left_q == CNT_W'(1)) || stop_q || stop;
          end
        end

        ST_UPDATE: begin
          if (done_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= ST_SEND;
            jobs_left_q <= jobs_left_q - CNT_W'(1);
            idx_q       <= '0;
            tvalid_q    <= 1'b1;
            tdata_q     <= job_q[0];
            tlast_q     <= (JOB_LAST == '0);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign jobs_done       = jobs_done_q;
  assign cur_nonce       = job_q[NONCE_INDEX];
  assign result_valid    = rv_q;
  assign proto_err       = perr_q;
  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tdata  = tdata_q;
  assign m00_axis.tstrb  = {(W/8){tvalid_q}};
  assign m00_axis.tlast  = tlast_q;
  assign s00_axis.tready = s_tready_q;

endmodule

// File: tb/tb_miner_job_driver.sv
// Randomized bench for miner_job_driver: acts as both stream peers against a job/result model.
module tb_miner_job_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        start = 1'b0;
  logic [15:0] run_count = '0;
  logic        stop = 1'b0;
  logic        busy, done, result_valid, proto_err;
  logic [15:0] jobs_done;
  logic [31:0] cur_nonce;
  logic [255:0] result_data;

  miner_job_driver_if #(.W(32)) m00 ();
  miner_job_driver_if #(.W(32)) s00 ();

  miner_job_driver dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .start        (start),
    .run_count    (run_count),
    .stop         (stop),
    .busy         (busy),
    .done         (done),
    .jobs_done    (jobs_done),
    .cur_nonce    (cur_nonce),
    .result_data  (result_data),
    .result_valid (result_valid),
    .proto_err    (proto_err),
    .m00_axis     (m00),
    .s00_axis     (s00)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_job [20];
  logic [31:0] model_res [8];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack_res();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[255-32*k -: 32] = model_res[k];
    return v;
  endfunction

  task automatic write_job(input int a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'(a); cfg_wdata = d;
    if (a < 20) model_job[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One full run: the bench is the job sink and the result source.
  task automatic do_run(input int rc, input bit bp, input bit slv_rand, input int short_at,
                        input bit omit_last, input int stop_job, input bit busy_poke,
                        input bit timing_chk, input logic [31:0] seed);
    int exp_jobs, job, beat, sbeat, rv_cnt, cyc, last_shs, last_idx;
    bit got_done, pending, prev_stall, prev_rv, prev_last, exp_perr;
    logic [31:0] prev_data;
    exp_jobs = (rc == 0) ? 1 : rc;
    if (stop_job > 0 && stop_job < exp_jobs) exp_jobs = stop_job;
    last_idx = (short_at >= 0) ? short_at : 7;
    exp_perr = (short_at >= 0 && short_at < 7) || omit_last;
    job = 0; beat = 0; sbeat = 0; rv_cnt = 0; cyc = 0; last_shs = -100;
    got_done = 0; pending = 0; prev_stall = 0; prev_rv = 0; prev_last = 0; prev_data = '0;

    @(negedge clk);
    start = 1'b1; run_count = 16'(rc);
    while (!got_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; cfg_we = 1'b0; stop = 1'b0;

      if (cyc == 1) begin
        chk("tvalid_after_start", 1'(m00.tvalid), 1'b1);
        chk("busy_after_start", 1'(busy), 1'b1);
        chk("perr_cleared", 1'(proto_err), 1'b0);
        chk("jobs_done_cleared", 256'(jobs_done), 256'd0);
      end
      if (m00.tvalid && prev_stall) begin
        chk("stall_tdata", 256'(m00.tdata), 256'(prev_data));
        chk("stall_tlast", 1'(m00.tlast), prev_last);
      end
      if (prev_rv) chk("rv_pulse", 1'(result_valid), 1'b0);
      prev_rv = result_valid;
      if (result_valid) begin
        rv_cnt++;
        chk("rv_latency", 256'(cyc - last_shs), 256'd1);
        chk("result_data", result_data, pack_res());
        chk("jobs_done_rv", 256'(jobs_done), 256'(rv_cnt));
        chk("s_tready_upd", 1'(s00.tready), 1'b0);
      end
      if (done) begin
        got_done = 1;
        chk("jobs_done_end", 256'(jobs_done), 256'(exp_jobs));
        chk("rv_count", 256'(rv_cnt), 256'(exp_jobs));
        chk("cur_nonce", 256'(cur_nonce), 256'(model_job[19]));
        chk("proto_err", 1'(proto_err), exp_perr);
        if (timing_chk && exp_jobs == 1) chk("run_cycles", 256'(cyc), 256'd29);
      end

      m00.tready = bp ? ((cyc / 2) % 2 == 0) : 1'b1;
      if (m00.tvalid && beat == 0) chk("s_tready_send", 1'(s00.tready), 1'b0);
      if (m00.tvalid && beat == 0 && job > 0 && !bp && timing_chk)
        chk("b2b_gap", 256'(cyc - last_shs), 256'd2);
      if (m00.tvalid && m00.tready) begin
        chk("tdata", 256'(m00.tdata), 256'(model_job[beat]));
        chk("tlast", 1'(m00.tlast), 1'(beat == 19));
        chk("tstrb", 256'(m00.tstrb), 256'hF);
        beat++;
        if (beat == 20) begin beat = 0; sbeat = 0; pending = 1; end
      end
      prev_stall = m00.tvalid && !m00.tready;
      prev_data  = m00.tdata;
      prev_last  = m00.tlast;

      if (stop_job > 0 && job == stop_job - 1 && beat == 5) stop = 1'b1;
      if (busy_poke && job == 1 && beat == 3) begin
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 32'hDEADBEEF; start = 1'b1;
      end

      if (pending) begin
        s00.tvalid = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        s00.tdata  = 32'((32'hA0 + sbeat + (job << 8))) ^ seed;
        s00.tlast  = (sbeat == last_idx) && !omit_last;
        if (s00.tvalid && s00.tready) begin
          model_res[sbeat] = s00.tdata;
          if (sbeat == last_idx) begin
            pending = 0; last_shs = cyc; job++;
            model_job[19] = model_job[19] + 32'd1;
          end
          sbeat++;
        end
      end else begin
        s00.tvalid = 1'b0; s00.tlast = 1'b0;
      end
    end
    if (!got_done) chk("done_timeout", 1'b0, 1'b1);
    @(negedge clk);
    s00.tvalid = 1'b0; m00.tready = 1'b1;
    chk("busy_after_done", 1'(busy), 1'b0);
    chk("done_pulse", 1'(done), 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 20; i++) model_job[i] = '0;
    for (int k = 0; k < 8; k++) model_res[k] = '0;
    m00.tready = 1'b1;
    s00.tvalid = 1'b0; s00.tdata = '0; s00.tstrb = 4'hF; s00.tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 1'(busy), 1'b0);
    chk("rst_tvalid", 1'(m00.tvalid), 1'b0);
    chk("rst_result", result_data, 256'd0);
    chk("rst_nonce", 256'(cur_nonce), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_tready", 1'(s00.tready), 1'b0);

    // Single job, then out-of-range write must be ignored.
    for (int i = 0; i < 19; i++) write_job(i, 32'(i + 1));
    write_job(19, 32'h10);
    write_job(25, 32'h55);
    do_run(1, 0, 0, -1, 0, 0, 0, 1, 32'h0);

    // Nonce sweep across the 32-bit wrap.
    write_job(19, 32'hFFFFFFFE);
    do_run(3, 0, 0, -1, 0, 0, 0, 1, 32'h0);
    chk("sweep_nonce", 256'(cur_nonce), 256'd1);

    // Backpressure on both sides with the single-job header.
    write_job(19, 32'h10);
    do_run(1, 1, 1, -1, 0, 0, 0, 0, 32'h0);

    // Random header, stop in idle has no effect, run_count 0 behaves as 1.
    for (int i = 0; i < 20; i++) write_job(i, $urandom);
    @(negedge clk); stop = 1'b1; @(negedge clk); stop = 1'b0;
    do_run(2, 1, 1, -1, 0, 0, 0, 0, $urandom);
    do_run(0, 0, 1, -1, 0, 0, 0, 0, $urandom);

    // Short packet, then missing tlast.
    do_run(1, 0, 1, 5, 0, 0, 0, 0, $urandom);
    do_run(1, 0, 1, -1, 1, 0, 0, 0, $urandom);

    // Stop mid-sweep plus writes/starts while busy.
    do_run(10, 0, 1, -1, 0, 2, 1, 0, $urandom);
    do_run(1, 1, 0, -1, 0, 0, 0, 0, $urandom);

    // Asynchronous reset while beat 7 is on the bus.
    @(negedge clk);
    start = 1'b1; run_count = 16'd1; m00.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_tdata", 256'(m00.tdata), 256'(model_job[7]));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 1'(m00.tvalid), 1'b0);
    chk("arst_tdata", 256'(m00.tdata), 256'd0);
    chk("arst_busy", 1'(busy), 1'b0);
    chk("arst_nonce", 256'(cur_nonce), 256'd0);
    chk("arst_result", result_data, 256'd0);
    chk("arst_jobs_done", 256'(jobs_done), 256'd0);
    for (int i = 0; i < 20; i++) model_job[i] = '0;
    for (int k = 0; k < 8; k++) model_res[k] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_run(1, 0, 0, -1, 0, 0, 0, 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/miner_job_driver.md
Name: miner_job_driver

Overview:
- AXI-Stream job source and result sink for the bitcoin miner stream IP.
- Holds a 20-word block-header job loaded through a simple register write port, and streams it as one 20-word packet on the master port.
- Collects the 8-word hash packet returned on the slave port.
- Optionally repeats for N jobs, incrementing the nonce word after each result, so one block drives the miner for a sweep without CPU involvement.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, stream and job word width.
- JOB_WORDS, 20, words per transmitted job packet.
- RESULT_WORDS, 8, words per received result packet.
- NONCE_INDEX, 19, job word incremented between jobs.
- CNT_W, 16, width of run_count and jobs_done.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  asynchronous, active-low reset.
- cfg_we  in  1  job word write strobe; ignored while busy.
- cfg_addr  in  5  job word index, 0..JOB_WORDS-1; writes to indices >= JOB_WORDS are ignored.
- cfg_wdata  in  32  job word data.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- run_count  in  CNT_W  jobs per run, sampled at start; 0 is treated as 1.
- stop  in  1  finish the current job, then end the run.
- busy  out  1  high from the cycle after start is accepted until the done cycle.
- done  out  1  one-cycle pulse at run end.
- jobs_done  out  CNT_W  results received in the current or last run.
- cur_nonce  out  32  live value of job[NONCE_INDEX].
- result_data  out  256  last result; word 0 in bits [255:224].
- result_valid  out  1  one-cycle pulse when result_data updates.
- proto_err  out  1  sticky tlast error flag; cleared at start.
- m00_axis_tvalid / tdata[31:0] / tstrb[3:0] / tlast  out  master side.
- m00_axis_tready  in  1  master side.
- s00_axis_tready  out  1  slave side.
- s00_axis_tdata[31:0] / tstrb[3:0] / tlast / tvalid  in  slave side.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; job registers, counters and result_data 0. A reset mid-packet abandons the packet immediately; no flush.
- States:
  - IDLE -> SEND on start. Loads jobs_left = max(run_count, 1), clears jobs_done and proto_err, word index = 0. tvalid first asserts the cycle after start.
  - SEND: m00_axis_tvalid=1, tdata=job[idx], tstrb=4'hF, tlast=(idx==JOB_WORDS-1). idx advances only on tvalid&&tready. After the last handshake, go to RECV with idx=0.
  - RECV: s00_axis_tready=1. Each handshake writes result word idx. The packet ends on (idx==RESULT_WORDS-1) or tlast, whichever comes first, then go to UPDATE.
  - UPDATE, exactly one cycle:
    - result_valid=1; jobs_done += 1.
    - job[NONCE_INDEX] += 1, modulo 2^32, so FFFFFFFF wraps to 0.
    - If jobs_left==1 or stop has been seen since start: done=1 and go to IDLE. Otherwise jobs_left -= 1 and go to SEND.
- tvalid and tdata stay stable until handshake; job registers cannot change while busy.
- tready is held low outside RECV. The miner must not send early; slave data arriving outside RECV is not accepted.
- proto_err is set when tlast arrives on word < RESULT_WORDS-1 (short packet; missing words keep their old values) or when tlast is absent on word RESULT_WORDS-1.
- The stop request is latched. Asserting stop in IDLE has no effect.
- A start in the same cycle as done is ignored.
- Back-to-back jobs: 1 idle cycle (UPDATE) between the last slave handshake and the next tvalid.
- Minimum run time with always-ready peers: 1 + 20 + 8 + 1 cycles per job.

Decomposition:
- sha.vh (shared): WORD_S and H_SIZE widths, JOB_WORDS/RESULT_WORDS/NONCE_INDEX defaults, and the state encoding localparams (IDLE, SEND, RECV, UPDATE).
- One sub-module, miner_result_capture: the RECV-side word counter, 256-bit shift/index assembly and tlast checking. Its outputs are pkt_done and pkt_err.

Test Plan:
- Single job: write words 0..19 = i+1 and nonce=32'h10. Start with run_count=1, peers always ready. Expect 20 beats with tdata 1..19,0x10 and tlast on beat 19. Return 8 words A0..A7 with tlast. Expect result_data={A0..A7}, result_valid one pulse, done, jobs_done=1, cur_nonce=0x11.
- Sweep: run_count=3, nonce=FFFFFFFE. Expect transmitted nonces FFFFFFFE, FFFFFFFF, 00000000; three result_valid pulses; jobs_done=3; cur_nonce=1.
- Backpressure: toggle m00_axis_tready every 2 cycles and randomise slave tvalid. Expect tdata and tlast unchanged during stalls and the same beat order and results as the single-job test.
- Protocol error: tlast on result word 5. Expect UPDATE after 6 beats and proto_err=1. Then omit tlast on word 7 of the next run. Expect proto_err=1 again (it was cleared at start).
- Stop/ignore: run_count=10, pulse stop during job 2. Expect done after jobs_done=2. Also a cfg_we during busy leaves the job unchanged, and a start during busy is ignored.
- Async reset asserted mid-SEND at beat 7: all outputs 0 immediately and job registers 0. After release, a new start produces a clean 20-beat packet.
